// File: rtl/conv11_input_feeder.sv
// conv11 input feeder: reads VEC_LEN activation words per beat and holds each beat until consumed.
// Optional PRESENT watchdog enabled by defining CONV11_FEEDER_TIMEOUT_EN.
module conv11_input_feeder #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned VEC_LEN = 4,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [ADDR_W-1:0]         base_addr_i,
  input  logic [ADDR_W-1:0]         beat_count_i,
  output logic                      mem_rd_en_o,
  output logic [ADDR_W-1:0]         mem_rd_addr_o,
  input  logic [DATA_W-1:0]         mem_rd_data_i,
  output logic [VEC_LEN*DATA_W-1:0] input_data_o,
  output logic                      input_valid_o,
  input  logic                      input_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_timeout_o
);

  localparam int unsigned CntW = $clog2(VEC_LEN + 1);

  if (VEC_LEN == 0 || TIMEOUT == 0) begin : g_param_check
    $error("conv11_input_feeder: VEC_LEN and TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StFin} state_e;

  state_e                      state_q;
  logic [ADDR_W-1:0]           ptr_q;
  logic [ADDR_W-1:0]           beats_q;
  logic [CntW-1:0]             rd_cnt_q;
  logic [CntW-1:0]             cap_idx_q;
  logic                        cap_pend_q;
  logic                        mem_rd_en_q;
  logic [ADDR_W-1:0]           mem_rd_addr_q;
  logic [VEC_LEN*DATA_W-1:0]   data_q;
  logic                        valid_q;
  logic                        busy_q;
  logic                        done_q;

`ifdef CONV11_FEEDER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  logic [ToW-1:0] to_cnt_q;
  logic           err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      beats_q       <= '0;
      rd_cnt_q      <= '0;
      cap_idx_q     <= '0;
      cap_pend_q    <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef CONV11_FEEDER_TIMEOUT_EN
      to_cnt_q      <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      // Read data returns one cycle after the strobe, so the capture strobe trails it by one.
      cap_pend_q <= mem_rd_en_q;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (beat_count_i == '0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              state_q       <= StFetch;
              busy_q        <= 1'b1;
              beats_q       <= beat_count_i;
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= base_addr_i;
              ptr_q         <= base_addr_i + ADDR_W'(1);
              rd_cnt_q      <= CntW'(1);
              cap_idx_q     <= '0;
            end
          end
        end
        StFetch: begin
          if (rd_cnt_q < CntW'(VEC_LEN)) begin
            mem_rd_en_q   <= 1'b1;
            mem_rd_addr_q <= ptr_q;
            ptr_q         <= ptr_q + ADDR_W'(1);
            rd_cnt_q      <= rd_cnt_q + CntW'(1);
          end else begin
            mem_rd_en_q <= 1'b0;
          end
          if (cap_pend_q) begin
            data_q[cap_idx_q*DATA_W +: DATA_W] <= mem_rd_data_i;
            cap_idx_q <= cap_idx_q + CntW'(1);
            if (cap_idx_q == CntW'(VEC_LEN - 1)) begin
              state_q <= StPresent;
              valid_q <= 1'b1;
`ifdef CONV11_FEEDER_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end
        end
        StPresent: begin
          if (input_ready_i) begin
            valid_q <= 1'b0;
            if (beats_q == ADDR_W'(1)) begin
              state_q <= StFin;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              beats_q       <= beats_q - ADDR_W'(1);
              state_q       <= StFetch;
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= ptr_q;
              ptr_q         <= ptr_q + ADDR_W'(1);
              rd_cnt_q      <= CntW'(1);
              cap_idx_q     <= '0;
            end
          end
`ifdef CONV11_FEEDER_TIMEOUT_EN
          else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFin;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
`endif
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_rd_en_o   = mem_rd_en_q;
  assign mem_rd_addr_o = mem_rd_addr_q;
  assign input_data_o  = data_q;
  assign input_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
`ifdef CONV11_FEEDER_TIMEOUT_EN
  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_conv11_input_feeder.sv
// Directed bench for conv11_input_feeder: reset, single beat, wrap, ignored inputs,
// back-to-back consumer and watchdog behaviour (CONV11_FEEDER_TIMEOUT_EN).
module tb_conv11_input_feeder;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned VEC_LEN = 4;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start;
  logic [ADDR_W-1:0]         base_addr;
  logic [ADDR_W-1:0]         beat_count;
  logic                      mem_rd_en;
  logic [ADDR_W-1:0]         mem_rd_addr;
  logic [DATA_W-1:0]         mem_rd_data;
  logic [VEC_LEN*DATA_W-1:0] input_data;
  logic                      input_valid;
  logic                      input_ready;
  logic                      busy;
  logic                      done;
  logic                      err_timeout;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int viol_cnt    = 0;
  int rd_cnt      = 0;
  logic last_ready = 1'b0;

  conv11_input_feeder #(
    .DATA_W (DATA_W),
    .VEC_LEN(VEC_LEN),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .beat_count_i (beat_count),
    .mem_rd_en_o  (mem_rd_en),
    .mem_rd_addr_o(mem_rd_addr),
    .mem_rd_data_i(mem_rd_data),
    .input_data_o (input_data),
    .input_valid_o(input_valid),
    .input_ready_i(input_ready),
    .busy_o       (busy),
    .done_o       (done),
    .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = a[7:0], valid only in the cycle after the strobe.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_rd_addr[7:0] : 8'hA5;

  always @(negedge clk) begin
    if (last_ready && input_valid) viol_cnt++;
    if (done) done_cnt++;
    if (mem_rd_en) rd_cnt++;
    last_ready = input_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; beat_count = '0; input_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    base_addr = 12'h300; beat_count = 12'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    vectors++;
    if (mem_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_prefetch: got rd_en %b expected 1", mem_rd_en);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_rd_en, mem_rd_addr, input_data, input_valid, busy, done, err_timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h v=%b busy=%b done=%b err=%b expected all 0",
               mem_rd_en, mem_rd_addr, input_data, input_valid, busy, done, err_timeout);
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if ({mem_rd_en, input_valid, busy, done} !== 4'b0) begin
        miscompares++;
        $display("FAIL reset_idle: cycle %0d got en=%b v=%b busy=%b done=%b expected 0",
                 i, mem_rd_en, input_valid, busy, done);
      end
    end
  endtask

  task automatic test_single();
    logic [ADDR_W-1:0] ea;
    base_addr = 12'h010; beat_count = 12'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ea = 12'h010 + 12'(i);
      vectors++;
      if ({mem_rd_en, mem_rd_addr} !== {1'b1, ea}) begin
        miscompares++;
        $display("FAIL single_read%0d: got en=%b addr=%h expected en=1 addr=%h", i, mem_rd_en, mem_rd_addr, ea);
      end
      step();
    end
    vectors++;
    if ({mem_rd_en, input_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_c5: got en=%b v=%b expected 0 0", mem_rd_en, input_valid);
    end
    step();
    vectors++;
    if ({input_valid, busy, input_data} !== {2'b11, 32'h13121110}) begin
      miscompares++;
      $display("FAIL single_beat: got v=%b busy=%b data=%h expected 1 1 13121110", input_valid, busy, input_data);
    end
    repeat (2) step();
    vectors++;
    if ({input_valid, input_data} !== {1'b1, 32'h13121110}) begin
      miscompares++;
      $display("FAIL single_hold: got v=%b data=%h expected 1 13121110", input_valid, input_data);
    end
    step();
    input_ready = 1'b1;
    step();
    input_ready = 1'b0;
    vectors++;
    if ({input_valid, done, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL single_done: got v=%b done=%b busy=%b expected 0 1 0", input_valid, done, busy);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done_pulse: got done=%b expected 0", done);
    end
  endtask

  task automatic test_wrap();
    int d0;
    logic [ADDR_W-1:0] ea;
    d0 = done_cnt;
    base_addr = 12'hFFE; beat_count = 12'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ea = 12'hFFE + 12'(i);
      vectors++;
      if ({mem_rd_en, mem_rd_addr} !== {1'b1, ea}) begin
        miscompares++;
        $display("FAIL wrap_read%0d: got en=%b addr=%h expected en=1 addr=%h", i, mem_rd_en, mem_rd_addr, ea);
      end
      step();
    end
    step();
    vectors++;
    if ({input_valid, input_data} !== {1'b1, 32'h0100FFFE}) begin
      miscompares++;
      $display("FAIL wrap_beat0: got v=%b data=%h expected 1 0100fffe", input_valid, input_data);
    end
    input_ready = 1'b1;
    step();
    input_ready = 1'b0;
    vectors++;
    if (input_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_valid_drop: got v=%b expected 0", input_valid);
    end
    for (int i = 0; i < 4; i++) begin
      ea = 12'h002 + 12'(i);
      vectors++;
      if ({mem_rd_en, mem_rd_addr} !== {1'b1, ea}) begin
        miscompares++;
        $display("FAIL wrap_read_b1_%0d: got en=%b addr=%h expected en=1 addr=%h", i, mem_rd_en, mem_rd_addr, ea);
      end
      step();
    end
    step();
    vectors++;
    if ({input_valid, input_data} !== {1'b1, 32'h05040302}) begin
      miscompares++;
      $display("FAIL wrap_beat1: got v=%b data=%h expected 1 05040302", input_valid, input_data);
    end
    input_ready = 1'b1;
    step();
    input_ready = 1'b0;
    vectors++;
    if ({done, input_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL wrap_done: got done=%b v=%b expected 1 0", done, input_valid);
    end
    step();
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL wrap_done_count: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_zero_ignored();
    int d0;
    int r0;
    logic [ADDR_W-1:0] ea;
    d0 = done_cnt; r0 = rd_cnt;
    base_addr = 12'h020; beat_count = 12'd0; start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({done, input_valid, busy, mem_rd_en} !== 4'b1000) begin
      miscompares++;
      $display("FAIL zero_done: got done=%b v=%b busy=%b en=%b expected 1 0 0 0", done, input_valid, busy, mem_rd_en);
    end
    step();
    vectors++;
    if ({done, rd_cnt - r0} !== {1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL zero_no_read: got done=%b reads=%0d expected 0 0", done, rd_cnt - r0);
    end
    base_addr = 12'h100; beat_count = 12'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    // Restart attempt and stray ready while fetching.
    start = 1'b1; base_addr = 12'h200; beat_count = 12'd5; input_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      ea = 12'h100 + 12'(i);
      vectors++;
      if ({mem_rd_en, mem_rd_addr} !== {1'b1, ea}) begin
        miscompares++;
        $display("FAIL ignore_read%0d: got en=%b addr=%h expected en=1 addr=%h", i, mem_rd_en, mem_rd_addr, ea);
      end
      step();
      if (i == 2) begin
        start = 1'b0; input_ready = 1'b0;
      end
    end
    step();
    vectors++;
    if ({input_valid, input_data} !== {1'b1, 32'h03020100}) begin
      miscompares++;
      $display("FAIL ignore_beat: got v=%b data=%h expected 1 03020100", input_valid, input_data);
    end
    input_ready = 1'b1;
    step();
    input_ready = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_done: got done=%b expected 1", done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({busy, mem_rd_en} !== 2'b00) begin
        miscompares++;
        $display("FAIL ignore_idle%0d: got busy=%b en=%b expected 0 0", i, busy, mem_rd_en);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 2) begin
      miscompares++;
      $display("FAIL ignore_done_count: got %0d expected 2", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    int v0;
    int waits;
    logic [31:0] exp;
    d0 = done_cnt; v0 = viol_cnt;
    base_addr = 12'h040; beat_count = 12'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 4; i++) exp[8*i +: 8] = 8'(32'h40 + 4*b + i);
      waits = 0;
      while (!input_valid && waits < 20) begin
        step();
        waits++;
      end
      vectors++;
      if (waits !== 5) begin
        miscompares++;
        $display("FAIL b2b_latency%0d: got %0d cycles expected 5", b, waits);
      end
      vectors++;
      if (input_data !== exp) begin
        miscompares++;
        $display("FAIL b2b_data%0d: got %h expected %h", b, input_data, exp);
      end
      repeat (2) step();
      vectors++;
      if ({input_valid, input_data} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL b2b_hold%0d: got v=%b data=%h expected 1 %h", b, input_valid, input_data, exp);
      end
      input_ready = 1'b1;
      step();
      input_ready = 1'b0;
    end
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_done: got done=%b busy=%b expected 1 0", done, busy);
    end
    step();
    vectors++;
    if ({done_cnt - d0, viol_cnt - v0} !== {32'd1, 32'd0}) begin
      miscompares++;
      $display("FAIL b2b_counts: got done=%0d stale_valid=%0d expected 1 0", done_cnt - d0, viol_cnt - v0);
    end
  endtask

`ifdef CONV11_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int waits;
    base_addr = 12'h080; beat_count = 12'd1; start = 1'b1;
    step();
    start = 1'b0;
    waits = 0;
    while (!input_valid && waits < 20) begin
      step();
      waits++;
    end
    vectors++;
    if (waits !== 5) begin
      miscompares++;
      $display("FAIL to_latency: got %0d expected 5", waits);
    end
    for (int k = 1; k < 16; k++) begin
      step();
      vectors++;
      if ({input_valid, err_timeout} !== 2'b10) begin
        miscompares++;
        $display("FAIL to_wait%0d: got v=%b err=%b expected 1 0", k, input_valid, err_timeout);
      end
    end
    step();
    vectors++;
    if ({err_timeout, input_valid, done} !== 3'b101) begin
      miscompares++;
      $display("FAIL to_fire: got err=%b v=%b done=%b expected 1 0 1", err_timeout, input_valid, done);
    end
    step();
    vectors++;
    if ({err_timeout, done, busy, mem_rd_en} !== 4'b1000) begin
      miscompares++;
      $display("FAIL to_after: got err=%b done=%b busy=%b en=%b expected 1 0 0 0", err_timeout, done, busy, mem_rd_en);
    end
    repeat (5) step();
    vectors++;
    if (err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL to_sticky: got err=%b expected 1", err_timeout);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL to_reset_clear: got err=%b expected 0", err_timeout);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask
`else
  task automatic test_no_timeout();
    int waits;
    base_addr = 12'h080; beat_count = 12'd1; start = 1'b1;
    step();
    start = 1'b0;
    waits = 0;
    while (!input_valid && waits < 20) begin
      step();
      waits++;
    end
    vectors++;
    if (waits !== 5) begin
      miscompares++;
      $display("FAIL nto_latency: got %0d expected 5", waits);
    end
    repeat (40) step();
    vectors++;
    if ({input_valid, err_timeout, done, input_data} !== {3'b100, 32'h83828180}) begin
      miscompares++;
      $display("FAIL nto_wait: got v=%b err=%b done=%b data=%h expected 1 0 0 83828180",
               input_valid, err_timeout, done, input_data);
    end
    input_ready = 1'b1;
    step();
    input_ready = 1'b0;
    vectors++;
    if ({done, input_valid, err_timeout} !== 3'b100) begin
      miscompares++;
      $display("FAIL nto_done: got done=%b v=%b err=%b expected 1 0 0", done, input_valid, err_timeout);
    end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_zero_ignored();
    test_back_to_back();
`ifdef CONV11_FEEDER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
